instr_encoder_loader: RTL and testbench

//  Inverse of the instruction decoder: takes RISC-V RV32I instruction fields over a valid/ready

---
 rtl/enc_pkg.sv | 35 +++
 rtl/instr_encode.sv | 49 ++++
 rtl/instr_encoder_loader.sv | 119 +++++++++++
 tb/tb_instr_encoder_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and constants for the RV32I field encoder and the imem program loader.
package enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // True when imm is representable as a two's-complement value of the given bit width.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(imm) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I field packer with per-format immediate legality check.
module instr_encode
  import enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  fn3,
  input  logic        fn7_5,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt)
      FMT_R: begin
        word  = {1'b0, fn7_5, 5'b0, rs2, rs1, fn3, rd, opcode};
        legal = 1'b1;
      end
      FMT_I: begin
        word  = {imm[11:0], rs1, fn3, rd, opcode};
        legal = imm_fits(imm, 12);
      end
      FMT_S: begin
        word  = {imm[11:5], rs2, rs1, fn3, imm[4:0], opcode};
        legal = imm_fits(imm, 12);
      end
      FMT_B: begin
        word  = {imm[12], imm[10:5], rs2, rs1, fn3, imm[4:1], imm[11], opcode};
        legal = imm_fits(imm, 13) && !imm[0];
      end
      FMT_U: begin
        word  = {imm[31:12], rd, opcode};
        legal = (imm[11:0] == '0);
      end
      FMT_J: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = imm_fits(imm, 21) && !imm[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts field bundles, encodes them and writes consecutive imem words.
module instr_encoder_loader
  import enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_last,
  input  logic [2:0]        op_fmt,
  input  logic [6:0]        op_opcode,
  input  logic [4:0]        op_rd,
  input  logic [4:0]        op_rs1,
  input  logic [4:0]        op_rs2,
  input  logic [2:0]        op_fn3,
  input  logic              op_fn7_5,
  input  logic [31:0]       op_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_imm,
  output logic              err_full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(DEPTH);

  state_e      state;
  logic        we_r;
  logic        last_r;
  logic [31:0] enc_word;
  logic        enc_legal;

  instr_encode u_encode (
    .fmt    (op_fmt),
    .opcode (op_opcode),
    .rd     (op_rd),
    .rs1    (op_rs1),
    .rs2    (op_rs2),
    .fn3    (op_fn3),
    .fn7_5  (op_fn7_5),
    .imm    (op_imm),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  // The word is encoded at the handshake edge; the strobe is masked so a reset
  // landing in the EMIT cycle never produces a write.
  assign imem_we = we_r & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_ready   <= 1'b0;
      we_r       <= 1'b0;
      last_r     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_imm    <= 1'b0;
      err_full   <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      count      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            op_ready  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            err_imm   <= 1'b0;
            err_full  <= 1'b0;
            imem_addr <= BASE;
            count     <= '0;
          end
        end
        LOAD: begin
          if (op_valid) begin
            state    <= EMIT;
            op_ready <= 1'b0;
            last_r   <= op_last;
            if (!enc_legal) err_imm <= 1'b1;
            if (count == FULL) err_full <= 1'b1;
            if (enc_legal && count != FULL) begin
              we_r       <= 1'b1;
              imem_wdata <= enc_word;
            end
          end
        end
        EMIT: begin
          we_r <= 1'b0;
          if (we_r) begin
            count <= count + 1'b1;
            if (imem_addr != '1) imem_addr <= imem_addr + 1'b1;
          end
          if (last_r) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= LOAD;
            op_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed program loads plus randomized bundles.
module tb_instr_encoder_loader;
  import enc_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset, start, op_valid, op_ready, op_last, op_fn7_5;
  logic [2:0]        op_fmt, op_fn3;
  logic [6:0]        op_opcode;
  logic [4:0]        op_rd, op_rs1, op_rs2;
  logic [31:0]       op_imm, imem_wdata;
  logic              imem_we, busy, done, err_imm, err_full;
  logic [ADDR_W-1:0] imem_addr;
  logic [ADDR_W:0]   count;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .op_valid(op_valid), .op_ready(op_ready),
    .op_last(op_last), .op_fmt(op_fmt), .op_opcode(op_opcode), .op_rd(op_rd),
    .op_rs1(op_rs1), .op_rs2(op_rs2), .op_fn3(op_fn3), .op_fn7_5(op_fn7_5),
    .op_imm(op_imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err_imm(err_imm), .err_full(err_full), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int m_addr, m_count;
  logic m_err_imm, m_err_full;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int fmt, input logic [31:0] op, rd, rs1, rs2,
                                           fn3, f7, imm);
    logic [31:0] w;
    w = 0;
    case (fmt)
      0: w = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (fn3 << 12) | (rd << 7) | op;
      1: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (fn3 << 12) | (rd << 7) | op;
      2: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (fn3 << 12)
             | ((imm & 32'h1F) << 7) | op;
      3: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
             | (rs1 << 15) | (fn3 << 12) | (((imm >> 1) & 32'hF) << 8)
             | (((imm >> 11) & 1) << 7) | op;
      4: w = (imm & 32'hFFFFF000) | (rd << 7) | op;
      5: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
             | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic bit ref_legal(input int fmt, input logic [31:0] imm);
    int s;
    s = imm;
    case (fmt)
      0:       return 1;
      1, 2:    return s >= -2048 && s <= 2047;
      3:       return s >= -4096 && s <= 4094 && imm[0] == 1'b0;
      4:       return (imm & 32'hFFF) == 0;
      5:       return s >= -(1 << 20) && s <= (1 << 20) - 2 && imm[0] == 1'b0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] rand_imm(input int fmt);
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = $urandom_range(0, 8191) - 4096;
      2:       v = $urandom_range(0, 1 << 21) - (1 << 20);
      default: v = $urandom_range(0, 40) - 20 + (($urandom_range(0, 1) == 1) ? 2048 : -2048);
    endcase
    if (fmt == 4 && $urandom_range(0, 1) == 1) v = v & 32'hFFFFF000;
    return v;
  endfunction

  task automatic check_reset_vals();
    check("rst_ready", 32'(op_ready), 0);
    check("rst_we", 32'(imem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err_imm", 32'(err_imm), 0);
    check("rst_err_full", 32'(err_full), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_count", 32'(count), 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_addr = 0; m_count = 0; m_err_imm = 0; m_err_full = 0;
    check("start_ready", 32'(op_ready), 1);
    check("start_busy", 32'(busy), 1);
    check("start_count", 32'(count), 0);
    check("start_done", 32'(done), 0);
  endtask

  task automatic send(input int fmt, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                      input logic [2:0] fn3, input logic f7, input logic [31:0] imm,
                      input bit last, input bit hold, input bit use_want,
                      input logic [31:0] want);
    int   w;
    bit   legal, exp_we;
    logic [31:0] exp_word;
    @(negedge clk);
    op_fmt = 3'(fmt); op_opcode = op; op_rd = rd; op_rs1 = rs1; op_rs2 = rs2;
    op_fn3 = fn3; op_fn7_5 = f7; op_imm = imm; op_last = last; op_valid = 1'b1;
    w = 0;
    while (op_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("handshake_ready", 32'(op_ready), 1);
    if (op_ready !== 1'b1) begin
      op_valid = 1'b0;
      return;
    end
    legal    = ref_legal(fmt, imm);
    exp_we   = legal && (m_count < DEPTH);
    exp_word = use_want ? want : ref_word(fmt, 32'(op), 32'(rd), 32'(rs1), 32'(rs2),
                                          32'(fn3), 32'(f7), imm);
    if (!legal) m_err_imm = 1;
    if (m_count >= DEPTH) m_err_full = 1;
    @(posedge clk);
    if (!hold) begin
      #1 op_valid = 1'b0;
    end
    @(negedge clk);
    check("emit_we", 32'(imem_we), 32'(exp_we));
    if (exp_we) begin
      check("emit_addr", 32'(imem_addr), m_addr);
      check("emit_wdata", imem_wdata, exp_word);
      m_addr++;
      m_count++;
    end
    check("emit_ready", 32'(op_ready), 0);
    check("emit_err_imm", 32'(err_imm), 32'(m_err_imm));
    check("emit_err_full", 32'(err_full), 32'(m_err_full));
    @(negedge clk);
    op_valid = 1'b0;
    check("post_we", 32'(imem_we), 0);
    check("post_count", 32'(count), m_count);
    check("post_ready", 32'(op_ready), last ? 0 : 1);
    check("post_done", 32'(done), 32'(last));
    check("post_busy", 32'(busy), last ? 0 : 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_valid = 1'b0; op_last = 1'b0; op_fmt = '0;
    op_opcode = '0; op_rd = '0; op_rs1 = '0; op_rs2 = '0; op_fn3 = '0; op_fn7_5 = 1'b0;
    op_imm = '0;
    m_addr = 0; m_count = 0; m_err_imm = 0; m_err_full = 0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;

    // R-type add / sub
    do_start();
    send(0, OP_R, 3, 1, 2, 3'd0, 1'b0, 32'h0, 0, 0, 1, 32'h002081B3);
    send(0, OP_R, 3, 1, 2, 3'd0, 1'b1, 32'h0, 1, 0, 1, 32'h402081B3);

    // addi / lw / sw
    do_start();
    send(1, OP_I,    3, 1, 0, 3'd0, 1'b0, 32'd4, 0, 0, 1, 32'h00408193);
    send(1, OP_LOAD, 3, 1, 0, 3'd2, 1'b0, 32'd4, 0, 0, 1, 32'h0040A183);
    send(2, OP_S,    0, 2, 3, 3'd2, 1'b0, 32'd4, 1, 0, 1, 32'h00312223);

    // beq / jal / lui
    do_start();
    send(3, OP_B,   0, 2, 3, 3'd0, 1'b0, 32'd8,      0, 0, 1, 32'h00310463);
    send(5, OP_JAL, 1, 0, 0, 3'd0, 1'b0, 32'd8,      0, 0, 1, 32'h008000EF);
    send(4, OP_LUI, 3, 0, 0, 3'd0, 1'b0, 32'h1000,   1, 0, 1, 32'h000011B7);

    // Illegal immediates are dropped; next legal word lands at the unchanged address
    do_start();
    send(1, OP_I,   3, 1, 0, 3'd0, 1'b0, 32'd2048,   0, 0, 0, 32'h0);
    send(3, OP_B,   0, 2, 3, 3'd0, 1'b0, 32'd3,      0, 0, 0, 32'h0);
    send(4, OP_LUI, 3, 0, 0, 3'd0, 1'b0, 32'h1001,   0, 0, 0, 32'h0);
    send(1, OP_I,   3, 1, 0, 3'd0, 1'b0, 32'd4,      1, 0, 1, 32'h00408193);
    check("ill_err_imm", 32'(err_imm), 1);
    check("ill_count", 32'(count), 1);

    // Overflow of DEPTH words
    do_start();
    for (int unsigned k = 0; k < 5; k++)
      send(1, OP_I, 5'(k), 1, 0, 3'd0, 1'b0, 32'(k), (k == 4), 0, 0, 32'h0);
    check("full_err_full", 32'(err_full), 1);
    check("full_done", 32'(done), 1);
    check("full_count", 32'(count), 4);

    // Reset in the EMIT cycle aborts the write
    do_start();
    @(negedge clk);
    op_fmt = 3'd1; op_opcode = OP_I; op_rd = 5'd3; op_rs1 = 5'd1; op_fn3 = 3'd0;
    op_imm = 32'd4; op_last = 1'b0; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_emit_we", 32'(imem_we), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    m_addr = 0; m_count = 0; m_err_imm = 0; m_err_full = 0;

    // start during LOAD is ignored; op_valid held through EMIT is not re-accepted
    do_start();
    send(1, OP_I, 3, 1, 0, 3'd0, 1'b0, 32'd4, 0, 1, 1, 32'h00408193);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_start_count", 32'(count), 1);
    check("ign_start_busy", 32'(busy), 1);
    send(0, OP_R, 3, 1, 2, 3'd0, 1'b1, 32'h0, 1, 0, 1, 32'h402081B3);
    check("ign_start_final", 32'(count), 2);

    // Randomized loads
    for (int unsigned l = 0; l < 12; l++) begin
      int unsigned n;
      do_start();
      n = $urandom_range(1, DEPTH);
      for (int unsigned k = 0; k < n; k++) begin
        int fmt;
        fmt = $urandom_range(0, 7);
        send(fmt, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
             1'($urandom), rand_imm(fmt), (k == n - 1), 1'($urandom), 0, 32'h0);
      end
      check("rnd_err_imm", 32'(err_imm), 32'(m_err_imm));
      check("rnd_count", 32'(count), m_count);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
